// File: rtl/median_window_gen_pkg.sv
// Shared constants and helpers for the 3x3 median window generator.
// Element indices follow i = 3*row + col, with row 0 the oldest image row.
package median_window_gen_pkg;

    localparam int WIN  = 3;

    localparam int W_TL = 0;
    localparam int W_TC = 1;
    localparam int W_TR = 2;
    localparam int W_ML = 3;
    localparam int W_C  = 4;
    localparam int W_MR = 5;
    localparam int W_BL = 6;
    localparam int W_BC = 7;
    localparam int W_BR = 8;

    // Bit offset of window element (r, c) inside the flattened window bus
    function automatic int win_offset(input int r, input int c, input int width);
        return (WIN * r + c) * width;
    endfunction

endpackage

// File: rtl/median_window_gen_if.sv
// Pixel-in / window-out stream bundle between the window generator and its neighbours.
// The slave modport is the window generator; the master modport is the pixel source / window sink.
interface median_window_gen_if #(
    parameter int WIDTH = 16
);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_sof;
    logic                 out_valid;
    logic                 out_ready;
    logic [9*WIDTH-1:0]   out_win;
    logic                 out_eol;
    logic                 out_eof;

    modport master (
        output in_valid, in_data, in_sof, out_ready,
        input  in_ready, out_valid, out_win, out_eol, out_eof
    );

    modport slave (
        input  in_valid, in_data, in_sof, out_ready,
        output in_ready, out_valid, out_win, out_eol, out_eof
    );

endinterface

// File: rtl/median_window_gen_line_buffer.sv
// One image row of storage: combinational read and synchronous write at the same column address.
// Contents are never reset; the window generator never emits anything built from an unwritten entry.
module median_window_gen_line_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read returns the pre-write value, so a chained buffer sees the older row
    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/median_window_gen.sv
// Streaming 3x3 window generator: two chained line buffers feed a 3x3 shift window,
// and one window is emitted per interior pixel for the downstream sort network.
module median_window_gen
    import median_window_gen_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                clk,
    input  logic                rst,
    median_window_gen_if.slave  bus
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic [CW-1:0]      col_idx;
    logic [RW-1:0]      row_idx;
    logic               ready;
    logic               accept;
    logic [WIDTH-1:0]   lb0_rd;
    logic [WIDTH-1:0]   lb1_rd;
    logic [WIDTH-1:0]   win_q [WIN][WIN];
    logic [9*WIDTH-1:0] win_flat;
    logic               out_valid_q;
    logic               out_eol_q;
    logic               out_eof_q;

    assign ready   = !out_valid_q || bus.out_ready;
    assign accept  = bus.in_valid && ready;

    // A start-of-frame pixel is (0, 0) regardless of where the counters stand
    assign col_idx = bus.in_sof ? '0 : col;
    assign row_idx = bus.in_sof ? '0 : row;

    median_window_gen_line_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (IMG_W),
        .AW    (CW)
    ) lb0 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col_idx),
        .wr_data (bus.in_data),
        .rd_data (lb0_rd)
    );

    median_window_gen_line_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (IMG_W),
        .AW    (CW)
    ) lb1 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col_idx),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col         <= '0;
            row         <= '0;
            out_valid_q <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < WIN; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb1_rd;
            win_q[1][2] <= lb0_rd;
            win_q[2][2] <= bus.in_data;

            // Stale columns from the previous row are flushed before c reaches 2
            out_valid_q <= (row_idx >= RW'(2)) && (col_idx >= CW'(2));
            out_eol_q   <= (col_idx == LAST_COL);
            out_eof_q   <= (col_idx == LAST_COL) && (row_idx == LAST_ROW);

            if (col_idx == LAST_COL) begin
                col <= '0;
                row <= (row_idx == LAST_ROW) ? '0 : row_idx + 1'b1;
            end else begin
                col <= col_idx + 1'b1;
                row <= row_idx;
            end
        end else begin
            out_valid_q <= out_valid_q && !bus.out_ready;
        end
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                win_flat[win_offset(r, c, WIDTH) +: WIDTH] = win_q[r][c];
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_win   = win_flat;
    assign bus.out_eol   = out_eol_q;
    assign bus.out_eof   = out_eof_q;

endmodule
